// File: rtl/cdc_hs_pkg.sv
// Shared definitions for the four-phase req/ack CDC handshake.
// Holds the receiver FSM state encoding and the width/depth defaults
// used by both the domain-A driver and the domain-B receiver.
package cdc_hs_pkg;

  localparam int unsigned DATA_W_DEF      = 4;
  localparam int unsigned CNT_W_DEF       = 8;
  // Also used for the driver's ack synchronizer; keep the two sides aligned.
  localparam int unsigned SYNC_STAGES_DEF = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    ACK  = 2'd2
  } state_t;

endpackage

// File: rtl/data_receiver_if.sv
// Bundle of the handshake and downstream signals around data_receiver.
//   req      : request from domain A (asynchronous to the receiver clock)
//   data_in  : word from domain A, stable while req is high
//   ack      : registered acknowledge back to domain A
//   data_out : captured word
//   valid    : data_out holds an unaccepted word
//   ready    : downstream consumer accepts data_out
//   xfer_cnt : count of accepted words, wraps
//   seq_err  : sticky sequence error
// Modports: slave = receiver view, master = sender/consumer view.
interface data_receiver_if #(
  parameter int unsigned DATA_W = 4,
  parameter int unsigned CNT_W  = 8
);
  logic              req;
  logic [DATA_W-1:0] data_in;
  logic              ack;
  logic [DATA_W-1:0] data_out;
  logic              valid;
  logic              ready;
  logic [CNT_W-1:0]  xfer_cnt;
  logic              seq_err;

  modport slave (
    input  req, data_in, ready,
    output ack, data_out, valid, xfer_cnt, seq_err
  );

  modport master (
    output req, data_in, ready,
    input  ack, data_out, valid, xfer_cnt, seq_err
  );
endinterface

// File: rtl/cdc_sync_bit.sv
// Multi-flop single-bit synchronizer with synchronous active-high reset to 0.
//   clk : destination clock
//   rst : synchronous, active-high reset
//   d   : asynchronous input bit
//   q   : synchronized output (last stage)
module cdc_sync_bit
  import cdc_hs_pkg::*;
#(
  parameter int unsigned STAGES = SYNC_STAGES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  always_ff @(posedge clk) begin
    if (rst) chain <= '0;
    else     chain <= {chain[STAGES-2:0], d};
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/data_receiver.sv
// Receive side of a four-phase req/ack handshake moving a word from
// domain A into domain B. The request is synchronized and edge-detected,
// the word is captured on the rising edge and offered downstream with
// valid/ready; after acceptance ack is raised until the request drops.
// Ports:
//   i_clk_b : domain-B clock, the only clock
//   i_rst   : synchronous, active-high reset
//   bus     : data_receiver_if.slave (req, data_in, ack, data_out, valid,
//             ready, xfer_cnt, seq_err)
// Optional feature: define DATA_SEQ_CHECK_EN to flag captured words that
// are not the previous captured word + 1; otherwise seq_err is tied 0.
module data_receiver
  import cdc_hs_pkg::*;
#(
  parameter int unsigned DATA_W      = DATA_W_DEF,
  parameter int unsigned CNT_W       = CNT_W_DEF,
  parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic                  i_clk_b,
  input  logic                  i_rst,
  data_receiver_if.slave        bus
);

  logic              req_s;
  logic              req_edge;
  logic              req_rise;
  state_t            state;
  state_t            state_next;
  logic              load;
  logic              accept;
  logic              ack_q;
  logic [DATA_W-1:0] data_q;
  logic [CNT_W-1:0]  cnt_q;

  cdc_sync_bit #(.STAGES(SYNC_STAGES)) u_req_sync (
    .clk (i_clk_b),
    .rst (i_rst),
    .d   (bus.req),
    .q   (req_s)
  );

  always_ff @(posedge i_clk_b) begin
    if (i_rst) req_edge <= 1'b0;
    else       req_edge <= req_s;
  end

  assign req_rise = req_s & ~req_edge;

  always_comb begin
    state_next = state;
    load       = 1'b0;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        if (req_rise) begin
          load       = 1'b1;
          state_next = HOLD;
        end
      end
      HOLD: begin
        if (bus.ready) begin
          accept     = 1'b1;
          state_next = ACK;
        end
      end
      ACK: begin
        // Wait for the request to be seen low so the next word starts a
        // fresh four-phase cycle.
        if (!req_s) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk_b) begin
    if (i_rst) begin
      state  <= IDLE;
      ack_q  <= 1'b0;
      data_q <= '0;
      cnt_q  <= '0;
    end else begin
      state <= state_next;
      // Registered copy of (state == ACK), driven from the next state so it
      // lines up with the state register without a decode after it.
      ack_q <= (state_next == ACK);
      if (load)   data_q <= bus.data_in;
      if (accept) cnt_q  <= cnt_q + 1'b1;
    end
  end

  assign bus.ack      = ack_q;
  assign bus.data_out = data_q;
  assign bus.valid    = (state == HOLD);
  assign bus.xfer_cnt = cnt_q;

`ifdef DATA_SEQ_CHECK_EN
  logic [DATA_W-1:0] prev_q;
  logic              have_prev;
  logic              seq_err_q;

  always_ff @(posedge i_clk_b) begin
    if (i_rst) begin
      prev_q    <= '0;
      have_prev <= 1'b0;
      seq_err_q <= 1'b0;
    end else if (load) begin
      prev_q    <= bus.data_in;
      have_prev <= 1'b1;
      if (have_prev && (bus.data_in != DATA_W'(prev_q + 1'b1)))
        seq_err_q <= 1'b1;
    end
  end

  assign bus.seq_err = seq_err_q;
`else
  assign bus.seq_err = 1'b0;
`endif

endmodule

// File: tb/tb_data_receiver.sv
module tb_data_receiver;
  import cdc_hs_pkg::*;

`ifdef DATA_SEQ_CHECK_EN
  localparam bit SEQ_EN = 1'b1;
`else
  localparam bit SEQ_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   passed = 0;

  always #5 clk = ~clk;

  data_receiver_if #(.DATA_W(4), .CNT_W(8)) bus ();

  data_receiver #(.DATA_W(4), .CNT_W(8), .SYNC_STAGES(2)) dut (
    .i_clk_b (clk),
    .i_rst   (rst),
    .bus     (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.req = 1'b0;
    bus.ready = 1'b0;
    bus.data_in = '0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Full four-phase transfer with ready held high; every wait is bounded.
  task automatic xfer(input logic [3:0] w, input string tag, input logic exp_err);
    int n;
    bus.data_in = w;
    bus.req = 1'b1;
    bus.ready = 1'b1;
    n = 0;
    while (bus.valid !== 1'b1 && n < 20) begin tick(); n++; end
    check({tag, "_valid"}, bus.valid, 1);
    check({tag, "_data"}, bus.data_out, w);
    check({tag, "_seqerr"}, bus.seq_err, exp_err);
    n = 0;
    while (bus.ack !== 1'b1 && n < 20) begin tick(); n++; end
    check({tag, "_ack"}, bus.ack, 1);
    bus.req = 1'b0;
    n = 0;
    while (bus.ack !== 1'b0 && n < 20) begin tick(); n++; end
    check({tag, "_ackrel"}, bus.ack, 0);
  endtask

  initial begin
    bus.req = 1'b0;
    bus.ready = 1'b0;
    bus.data_in = '0;

    // Reset state
    do_reset();
    check("rst_ack", bus.ack, 0);
    check("rst_valid", bus.valid, 0);
    check("rst_data", bus.data_out, 0);
    check("rst_cnt", bus.xfer_cnt, 0);
    check("rst_seqerr", bus.seq_err, 0);

    // Single transfer, exact latency
    bus.data_in = 4'h5;
    bus.req = 1'b1;
    bus.ready = 1'b1;
    tick(); check("t1_e1_valid", bus.valid, 0);
    tick(); check("t1_e2_valid", bus.valid, 0);
    tick(); check("t1_e3_valid", bus.valid, 1);
            check("t1_e3_data", bus.data_out, 4'h5);
            check("t1_e3_ack", bus.ack, 0);
    tick(); check("t1_e4_ack", bus.ack, 1);
            check("t1_e4_valid", bus.valid, 0);
            check("t1_cnt", bus.xfer_cnt, 1);
    bus.req = 1'b0;
    tick(); check("t1_rel1_ack", bus.ack, 1);
    tick(); check("t1_rel2_ack", bus.ack, 1);
    tick(); check("t1_rel3_ack", bus.ack, 0);
            check("t1_data_hold", bus.data_out, 4'h5);

    // Backpressure with word A
    bus.data_in = 4'hA;
    bus.req = 1'b1;
    bus.ready = 1'b0;
    tick(); tick(); tick();
    check("bp_valid", bus.valid, 1);
    for (int i = 0; i < 10; i++) begin
      tick();
      check("bp_hold_valid", bus.valid, 1);
      check("bp_hold_data", bus.data_out, 4'hA);
      check("bp_hold_ack", bus.ack, 0);
    end
    check("bp_cnt_before", bus.xfer_cnt, 1);
    bus.ready = 1'b1;
    tick();
    check("bp_accept_ack", bus.ack, 1);
    check("bp_accept_valid", bus.valid, 0);
    check("bp_cnt", bus.xfer_cnt, 2);
    check("bp_seqerr", bus.seq_err, SEQ_EN);
    bus.req = 1'b0;
    tick(); tick(); tick();
    check("bp_ackrel", bus.ack, 0);

    // Back-to-back incrementing sequence 0..17 with wrap
    do_reset();
    for (int i = 0; i < 18; i++) begin
      logic [3:0] w;
      w = 4'(i);
      xfer(w, "seq", 1'b0);
    end
    check("seq_cnt", bus.xfer_cnt, 18);
    check("seq_last_data", bus.data_out, 4'h1);
    check("seq_seqerr", bus.seq_err, 0);

    // Reset while holding word 7 with req still high
    do_reset();
    bus.data_in = 4'h7;
    bus.req = 1'b1;
    bus.ready = 1'b0;
    tick(); tick(); tick();
    check("rh_valid", bus.valid, 1);
    check("rh_data", bus.data_out, 4'h7);
    rst = 1'b1;
    tick();
    check("rh_rst_valid", bus.valid, 0);
    check("rh_rst_ack", bus.ack, 0);
    check("rh_rst_data", bus.data_out, 0);
    tick();
    rst = 1'b0;
    tick(); check("rh_e1_valid", bus.valid, 0);
    tick(); check("rh_e2_valid", bus.valid, 0);
    tick(); check("rh_e3_valid", bus.valid, 1);
            check("rh_e3_data", bus.data_out, 4'h7);
    bus.ready = 1'b1;
    tick(); check("rh_ack", bus.ack, 1);
            check("rh_cnt", bus.xfer_cnt, 1);
    bus.req = 1'b0;
    tick(); tick(); tick();
    check("rh_ackrel", bus.ack, 0);

    // Sequence error: 1, 2, 4
    do_reset();
    xfer(4'h1, "se1", 1'b0);
    xfer(4'h2, "se2", 1'b0);
    xfer(4'h4, "se4", SEQ_EN);
    tick(); tick(); tick();
    check("se_sticky", bus.seq_err, SEQ_EN);
    check("se_cnt", bus.xfer_cnt, 3);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/data_receiver.md
# data_receiver

Receive side of the four-phase req/ack handshake that moves a multi-bit word from clock domain A into clock domain B. The block synchronizes the incoming request and captures the data word, which is stable while the request is high. It presents the word downstream with valid/ready and returns an acknowledge that the sender re-synchronizes. It sits in domain B, directly downstream of the domain-A data driver.

## Interface
- DATA_W, 4, width of transferred word
- CNT_W, 8, width of accepted-transfer counter
- SYNC_STAGES, 2, request synchronizer depth (legal: 2 or 3)

- i_clk_b  in  1  domain-B clock; the block's only clock
- i_rst  in  1  synchronous, active-high reset, sampled on i_clk_b
- i_data_req  in  1  request from domain A, asynchronous to i_clk_b
- i_data  in  DATA_W  word from domain A, stable while i_data_req is high
- o_data_ack  out  1  acknowledge to domain A, registered
- o_data  out  DATA_W  captured word
- o_data_valid  out  1  o_data holds an unaccepted word
- i_data_ready  in  1  downstream consumer accepts o_data
- o_xfer_cnt  out  CNT_W  count of accepted words, wraps
- o_seq_err  out  1  sticky sequence error (see Configuration)

## Operation
- Request path: i_data_req passes through a SYNC_STAGES flop chain, then one extra edge flop. req_s is the last sync stage; req_rise = req_s & !edge flop.
- FSM states: IDLE, HOLD, ACK.
  - IDLE: on req_rise, load i_data into the o_data register and go to HOLD. Otherwise stay in IDLE.
  - HOLD: o_data_valid=1. When o_data_valid & i_data_ready, increment o_xfer_cnt and go to ACK.
  - ACK: o_data_ack=1. When req_s==0, go to IDLE.
- o_data_valid is (state==HOLD). o_data_ack is registered, equal to (state==ACK).
- o_data holds its value outside capture. It is never loaded in HOLD or ACK.
- A new transfer cannot start until req_s has been observed low in ACK. This keeps the sequence strictly four-phase.
- o_xfer_cnt wraps modulo 2^CNT_W.
- Reset: state=IDLE; o_data_ack=0, o_data=0, o_data_valid=0, o_xfer_cnt=0, o_seq_err=0; all sync/edge flops=0.
  - Reset mid-transfer drops any held word.
  - If i_data_req is still high when reset is released, a req_rise is seen and the word is captured again.
- i_data_req glitches shorter than one clock are not supported. The sender guarantees req stays high until it sees ack.

## Timing
- Measured from the first i_clk_b edge that samples i_data_req=1, with SYNC_STAGES=2:
  - Edge 2: req_s=1, req_rise is true.
  - Edge 3: word captured; o_data_valid=1 after edge 3.
  - If i_data_ready is high, the accept happens on edge 4 and o_data_ack=1 after edge 4.
- Ack release: i_data_req falls, req_s=0 two edges later, and o_data_ack=0 one edge after that.
- Each extra synchronizer stage adds 1 cycle to both paths.
- i_data_ready low holds HOLD indefinitely. o_data and o_data_valid stay stable, and ack is not raised.

## Configuration
- DATA_SEQ_CHECK_EN defined:
  - Each captured word, except the first after reset, is compared against (previous captured word + 1) mod 2^DATA_W.
  - On mismatch, o_seq_err is set at the capture edge and stays set until reset.
  - The previous-word register is loaded on every capture.
- Not defined: the checker logic is absent and o_seq_err is tied 0. The port stays present.

## Structure
- Package cdc_hs_pkg holds:
  - the FSM state enum (IDLE, HOLD, ACK);
  - DATA_W and CNT_W defaults;
  - SYNC_STAGES default, shared with the driver's ack synchronizer.
- One sub-module: cdc_sync_bit, a SYNC_STAGES-deep single-bit synchronizer with synchronous active-high reset to 0, instantiated for i_data_req.

## Test plan
- Single transfer, i_data=4'h5, req held until ack, ready=1 → o_data=5 and valid after edge 3; ack after edge 4; ack low 3 edges after req falls; o_xfer_cnt=1.
- Backpressure: ready=0 for 10 cycles with word 4'hA → valid held 10+ cycles, o_data=A stable, ack stays 0 until the accept edge.
- Back-to-back sequence 0..17 with the sender incrementing → 18 words delivered in order, o_data wraps F→0, o_xfer_cnt=18, o_seq_err=0.
- Reset asserted in HOLD with word 4'h7 and req still high → valid=0 and ack=0 in reset; word 7 recaptured 3 edges after reset release.
- With DATA_SEQ_CHECK_EN, send 1,2,4 → o_seq_err=1 after the capture of 4 and sticky. Without the macro, same stimulus → o_seq_err=0.
